// File: rtl/avm_burst_arbiter_pkg.sv
// Shared types and constants for the two-master burst-aware Avalon-MM arbiter.
package avm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WBURST,
        RWAIT
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int AW_DEF  = 30;
    localparam int BCW_DEF = 4;

endpackage

// File: rtl/avm_burst_arbiter_if.sv
// Avalon-MM burst port bundle; master modport drives commands, slave modport answers them.
interface avm_burst_arbiter_if
    import avm_arb_pkg::*;
#(
    parameter int AW  = AW_DEF,
    parameter int BCW = BCW_DEF
);
    logic [AW-1:0]  address;
    logic [31:0]    writedata;
    logic [3:0]     byteenable;
    logic [BCW-1:0] burstcount;
    logic           write;
    logic           read;
    logic           waitrequest;
    logic           readdatavalid;
    logic [31:0]    readdata;

    modport master (
        output address, writedata, byteenable, burstcount, write, read,
        input  waitrequest, readdatavalid, readdata
    );

    modport slave (
        input  address, writedata, byteenable, burstcount, write, read,
        output waitrequest, readdatavalid, readdata
    );
endinterface

// File: rtl/avm_burst_arbiter_pick.sv
// Two-way request picker: one-hot winner from req and the last-served master.
// Define AVM_ARB_FIXED_PRIO_EN to make M0 win every tie instead of round-robin.
module avm_arb_pick
    import avm_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic [1:0] win
);

    always_comb begin
        win = req;
        if (&req) begin
`ifdef AVM_ARB_FIXED_PRIO_EN
            win = 2'b01;
`else
            win = (rr_last == M1) ? 2'b01 : 2'b10;
`endif
        end
    end

`ifdef AVM_ARB_FIXED_PRIO_EN
    logic unused_rr_last;
    assign unused_rr_last = rr_last;
`endif

endmodule

// File: rtl/avm_burst_arbiter.sv
// Two-master burst-aware Avalon-MM arbiter; grant held for a whole write burst or read response.
// Optional macro AVM_ARB_FIXED_PRIO_EN (in avm_arb_pick) selects fixed M0 priority on ties.
module avm_burst_arbiter
    import avm_arb_pkg::*;
#(
    parameter int AW  = AW_DEF,
    parameter int BCW = BCW_DEF
)
(
    input  logic                clk,
    input  logic                rst,
    avm_burst_arbiter_if.slave  m0,
    avm_burst_arbiter_if.slave  m1,
    avm_burst_arbiter_if.master s,
    output logic [1:0]          grant
);

    arb_state_t     state;
    logic [BCW-1:0] beats_left;
    logic           owner;
    logic           rr_last;

    logic [1:0]     req;
    logic [1:0]     win;
    logic           sel;
    logic           active;
    logic           sel_rd;
    logic           sel_wr;
    logic [AW-1:0]  sel_addr;
    logic [BCW-1:0] sel_bc;
    logic [BCW-1:0] bc_eff;
    logic           accept;

    assign req = {m1.read | m1.write, m0.read | m0.write};

    avm_arb_pick u_pick (
        .req     (req),
        .rr_last (rr_last),
        .win     (win)
    );

    // In IDLE the picker's winner steers the mux; once a burst is accepted the registered owner does.
    always_comb begin
        sel    = owner;
        active = 1'b0;
        if (state == IDLE) begin
            sel    = win[M1];
            active = |win;
        end else if (state == WBURST) begin
            active = 1'b1;
        end
        if (rst) begin
            active = 1'b0;
        end

        sel_rd   = sel ? m1.read       : m0.read;
        sel_wr   = sel ? m1.write      : m0.write;
        sel_addr = sel ? m1.address    : m0.address;
        sel_bc   = sel ? m1.burstcount : m0.burstcount;
        bc_eff   = (sel_bc == '0) ? BCW'(1) : sel_bc;

        s.address    = sel_addr;
        s.writedata  = sel ? m1.writedata  : m0.writedata;
        s.byteenable = sel ? m1.byteenable : m0.byteenable;
        s.burstcount = sel_bc;
        // Write beats read when a master raises both.
        s.write      = active & sel_wr;
        s.read       = active & (state == IDLE) & sel_rd & ~sel_wr;

        m0.waitrequest   = ~(active & (sel == M0)) | s.waitrequest;
        m1.waitrequest   = ~(active & (sel == M1)) | s.waitrequest;
        m0.readdatavalid = ~rst & (state == RWAIT) & (owner == M0) & s.readdatavalid;
        m1.readdatavalid = ~rst & (state == RWAIT) & (owner == M1) & s.readdatavalid;
        m0.readdata      = s.readdata;
        m1.readdata      = s.readdata;

        grant = '0;
        if (!rst) begin
            if (state == IDLE) begin
                grant = win;
            end else begin
                grant[owner] = 1'b1;
            end
        end
    end

    assign accept = (s.read | s.write) & ~s.waitrequest;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beats_left <= '0;
            owner      <= M0;
            rr_last    <= M1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner <= sel;
                        if (sel_wr) begin
                            if (bc_eff == BCW'(1)) begin
                                rr_last <= sel;
                            end else begin
                                state      <= WBURST;
                                beats_left <= bc_eff - BCW'(1);
                            end
                        end else begin
                            state      <= RWAIT;
                            beats_left <= bc_eff;
                        end
                    end
                end
                WBURST: begin
                    if (accept) begin
                        beats_left <= beats_left - BCW'(1);
                        if (beats_left == BCW'(1)) begin
                            state   <= IDLE;
                            rr_last <= owner;
                        end
                    end
                end
                RWAIT: begin
                    if (s.readdatavalid) begin
                        beats_left <= beats_left - BCW'(1);
                        if (beats_left == BCW'(1)) begin
                            state   <= IDLE;
                            rr_last <= owner;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
